// File: rtl/calc_pkg.sv
// Shared definitions for the infix calculator front end: operator codes,
// precedence lookup and the controller state encoding.
package calc_pkg;

  localparam logic [7:0] OP_ADD = 8'h2B;
  localparam logic [7:0] OP_SUB = 8'h2D;
  localparam logic [7:0] OP_MUL = 8'h2A;
  localparam logic [7:0] OP_DIV = 8'h2F;
  localparam logic [7:0] OP_EQ  = 8'h3D;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    FINISH
  } state_t;

  function automatic logic is_op_code(input logic [7:0] code);
    case (code)
      OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_EQ: is_op_code = 1'b1;
      default:                               is_op_code = 1'b0;
    endcase
  endfunction

  // '=' and unrecognised codes both map to 0; callers screen with is_op_code.
  function automatic logic [1:0] prec(input logic [7:0] code);
    case (code)
      OP_MUL, OP_DIV: prec = 2'd2;
      OP_ADD, OP_SUB: prec = 2'd1;
      default:        prec = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/lifo.sv
// Register-file stack with a combinational top-of-stack view (0 when empty).
// Push+pop together overwrites the top; pop on empty and push on full are dropped.
module lifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   sp;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] wr_idx;

  assign top_idx = AW'(sp - 1'b1);
  assign wr_idx  = sp[AW-1:0];
  assign empty   = (sp == '0);
  assign full    = (sp == (AW+1)'(DEPTH));
  assign count   = sp;
  assign dout    = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk) begin
    if (!clear) begin
      if (push && pop && !empty)
        mem[top_idx] <= din;
      else if (push && !full)
        mem[wr_idx] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sp <= '0;
    else if (clear)
      sp <= '0;
    else if (push && pop && !empty)
      sp <= sp;
    else if (push && !full)
      sp <= sp + 1'b1;
    else if (pop && !empty)
      sp <= sp - 1'b1;
  end

endmodule

// File: rtl/expr_ctrl.sv
// Infix front end: owns operand/operator stacks and sequences `calculation` via start/complete.
// Stack view 1 cycle after accept; tok_ready drops while a held operator forces a reduction.
module expr_ctrl
  import calc_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tok_valid,
  input  logic         tok_is_op,
  input  logic [W-1:0] tok_data,
  output logic         tok_ready,
  output logic         start,
  input  logic         complete,
  input  logic         opnd_pop,
  input  logic         opnd_push,
  input  logic         op_pop,
  input  logic [W-1:0] R,
  output logic [W-1:0] opnd_Dout,
  output logic [7:0]   op_Dout,
  output logic [W-1:0] result,
  output logic         done,
  output logic         err
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t        state;
  logic [7:0]    tok_code;
  logic          opnd_full, opnd_empty, op_full, op_empty;
  logic [CW-1:0] opnd_count, op_count;
  logic          in_idle, in_wait;
  logic          known_op, is_eq, reduce_req, lt_two, hold, accept;
  logic          tok_err, r_err, eq_finish, stk_clear;
  logic          opnd_push_i, opnd_pop_i, op_push_i, op_pop_i;
  logic [W-1:0]  opnd_din;

  assign tok_code = tok_data[7:0];
  assign in_idle  = (state == IDLE);
  assign in_wait  = (state == WAIT);
  assign known_op = is_op_code(tok_code);
  assign is_eq    = (tok_code == OP_EQ);

  // An operator that does not outrank the stacked one forces a reduction first
  // (>= gives left associativity; '=' flushes everything).
  assign reduce_req = in_idle && tok_valid && tok_is_op && known_op && !op_empty
                      && (prec(op_Dout) >= prec(tok_code));
  assign lt_two     = opnd_empty || (opnd_count == CW'(1));
  assign hold       = reduce_req && !lt_two;
  assign tok_ready  = in_idle && !hold;
  assign accept     = tok_valid && tok_ready;

  // A reduction request that reaches accept had too few operands.
  assign tok_err   = accept && (tok_is_op ? (!known_op || reduce_req || (!is_eq && op_full))
                                          : opnd_full);
  assign r_err     = in_wait && opnd_push && !opnd_pop && opnd_full;
  assign eq_finish = accept && tok_is_op && is_eq && op_empty;
  assign stk_clear = tok_err || r_err || (state == FINISH);

  assign opnd_din    = in_wait ? R : tok_data;
  assign opnd_push_i = (accept && !tok_is_op) || (in_wait && opnd_push);
  assign opnd_pop_i  = in_wait && opnd_pop;
  assign op_push_i   = accept && tok_is_op && known_op && !is_eq && !reduce_req;
  assign op_pop_i    = in_wait && op_pop;

  lifo #(.DEPTH(DEPTH), .W(W)) u_opnd (
    .clk   (clk),
    .reset (reset),
    .push  (opnd_push_i),
    .pop   (opnd_pop_i),
    .clear (stk_clear),
    .din   (opnd_din),
    .dout  (opnd_Dout),
    .full  (opnd_full),
    .empty (opnd_empty),
    .count (opnd_count)
  );

  lifo #(.DEPTH(DEPTH), .W(8)) u_op (
    .clk   (clk),
    .reset (reset),
    .push  (op_push_i),
    .pop   (op_pop_i),
    .clear (stk_clear),
    .din   (tok_code),
    .dout  (op_Dout),
    .full  (op_full),
    .empty (op_empty),
    .count (op_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      start  <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
    end else begin
      start <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (tok_err) begin
            err <= 1'b1;
          end else if (hold) begin
            start <= 1'b1;
            state <= START;
          end else if (eq_finish) begin
            state <= FINISH;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (r_err) begin
            err   <= 1'b1;
            state <= IDLE;
          end else if (complete) begin
            state <= IDLE;
          end
        end
        FINISH: begin
          if (opnd_count == CW'(1) && op_count == '0) begin
            result <= opnd_Dout;
            done   <= 1'b1;
          end else begin
            err <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_expr_ctrl.sv
// Bench for expr_ctrl: a behavioural `calculation` stub serves the stacks, and results are
// compared against a term/sum evaluator of the token stream.
module tb_expr_ctrl;

  localparam int DEPTH = 8;
  localparam int W     = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         tok_valid = 1'b0;
  logic         tok_is_op = 1'b0;
  logic [W-1:0] tok_data = '0;
  logic         tok_ready;
  logic         start;
  logic         complete = 1'b0;
  logic         opnd_pop = 1'b0;
  logic         opnd_push = 1'b0;
  logic         op_pop = 1'b0;
  logic [W-1:0] R = '0;
  logic [W-1:0] opnd_Dout;
  logic [7:0]   op_Dout;
  logic [W-1:0] result;
  logic         done;
  logic         err;

  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, err_cnt = 0, start_cnt = 0, overlap = 0;
  int done_cyc = 0, acc_cyc = 0, hold_viol = 0, calc_delay = 0;
  logic [W-1:0] last_res = '0;
  logic [8:0]   tq[$];

  expr_ctrl #(.DEPTH(DEPTH), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .tok_valid (tok_valid),
    .tok_is_op (tok_is_op),
    .tok_data  (tok_data),
    .tok_ready (tok_ready),
    .start     (start),
    .complete  (complete),
    .opnd_pop  (opnd_pop),
    .opnd_push (opnd_push),
    .op_pop    (op_pop),
    .R         (R),
    .opnd_Dout (opnd_Dout),
    .op_Dout   (op_Dout),
    .result    (result),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] apply(input logic [7:0] a, input logic [7:0] op, input logic [7:0] b);
    case (op)
      8'h2B:   return a + b;
      8'h2D:   return a - b;
      8'h2A:   return a * b;
      8'h2F:   return (b == 8'h00) ? 8'h00 : a / b;
      default: return 8'h00;
    endcase
  endfunction

  // Standard precedence: fold * and / into a running term, then add/subtract terms left to right.
  function automatic logic [7:0] ref_eval(input logic [7:0] v[$], input logic [7:0] o[$]);
    logic [7:0] sum, term, addop;
    sum = 8'h00;
    addop = 8'h2B;
    term = v[0];
    foreach (o[i]) begin
      if (o[i] == 8'h2A || o[i] == 8'h2F) begin
        term = apply(term, o[i], v[i+1]);
      end else begin
        sum = apply(sum, addop, term);
        addop = o[i];
        term = v[i+1];
      end
    end
    return apply(sum, addop, term);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_cnt <= done_cnt + 1;
      last_res <= result;
      done_cyc <= cyc;
    end
    if (err)   err_cnt   <= err_cnt + 1;
    if (start) start_cnt <= start_cnt + 1;
    if (start && (done || err)) overlap <= overlap + 1;
  end

  // Downstream calculation stub: pop b, then overwrite a with (a op b) while popping the op.
  always begin
    logic [7:0] a, b, o;
    bit abort;
    @(negedge clk); #2;
    if (start) begin
      @(negedge clk); #2;
      b = opnd_Dout;
      opnd_pop = 1'b1;
      @(negedge clk); #2;
      a = opnd_Dout;
      o = op_Dout;
      R = apply(a, o, b);
      opnd_push = 1'b1;
      op_pop = 1'b1;
      @(negedge clk); #2;
      opnd_pop = 1'b0;
      opnd_push = 1'b0;
      op_pop = 1'b0;
      abort = 1'b0;
      for (int i = 0; i < calc_delay; i++) begin
        if (tok_valid && tok_ready) hold_viol++;
        if (reset) begin
          abort = 1'b1;
          break;
        end
        @(negedge clk); #2;
      end
      if (!abort && !reset) begin
        complete = 1'b1;
        @(negedge clk); #2;
        complete = 1'b0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send_tok(input logic is_op, input logic [7:0] d);
    int n;
    n = 0;
    step();
    tok_valid = 1'b1;
    tok_is_op = is_op;
    tok_data  = d;
    #1;
    while (!tok_ready && n < 300) begin
      step();
      n++;
    end
    if (!tok_ready) chk("tok_ready timeout", {31'd0, tok_ready}, 1);
    acc_cyc = cyc;
    @(posedge clk);
  endtask

  task automatic tok_idle();
    step();
    tok_valid = 1'b0;
  endtask

  task automatic send_all();
    foreach (tq[i]) send_tok(tq[i][8], tq[i][7:0]);
    tok_idle();
    tq.delete();
  endtask

  task automatic expect_result(input string tag, input logic [7:0] exp_res, input int exp_starts,
                               input int d0, input int e0, input int s0);
    int n;
    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 1000) begin
      step();
      n++;
    end
    step();
    chk({tag, " done"}, done_cnt - d0, 1);
    chk({tag, " err"}, err_cnt - e0, 0);
    chk({tag, " result"}, {24'd0, last_res}, {24'd0, exp_res});
    if (exp_starts >= 0) chk({tag, " starts"}, start_cnt - s0, exp_starts);
  endtask

  initial begin
    int d0, e0, s0, h0, nops, n;
    logic [7:0] vals[$], ops[$];
    logic [7:0] o;

    repeat (3) step();
    chk("reset tok_ready", {31'd0, tok_ready}, 1);
    chk("reset start", {31'd0, start}, 0);
    chk("reset done", {31'd0, done}, 0);
    chk("reset err", {31'd0, err}, 0);
    chk("reset result", {24'd0, result}, 0);
    chk("reset opnd_Dout", {24'd0, opnd_Dout}, 0);
    chk("reset op_Dout", {24'd0, op_Dout}, 0);
    reset = 1'b0;

    // 3 + 4 =
    d0 = done_cnt; e0 = err_cnt; s0 = start_cnt;
    send_tok(1'b0, 8'd3);
    tok_idle();
    chk("opnd visible next cycle", {24'd0, opnd_Dout}, 3);
    send_tok(1'b1, 8'h2B);
    tok_idle();
    chk("op visible next cycle", {24'd0, op_Dout}, 32'h2B);
    send_tok(1'b0, 8'd4);
    send_tok(1'b1, 8'h3D);
    tok_idle();
    expect_result("3+4", 8'd7, 1, d0, e0, s0);
    chk("eq to done latency", done_cyc - acc_cyc, 2);

    // 2 + 3 * 4 =
    d0 = done_cnt; e0 = err_cnt; s0 = start_cnt;
    tq = '{9'h002, 9'h12B, 9'h003, 9'h12A, 9'h004, 9'h13D};
    send_all();
    expect_result("2+3*4", 8'd14, 2, d0, e0, s0);

    // 8 - 2 - 1 =
    d0 = done_cnt; e0 = err_cnt; s0 = start_cnt;
    tq = '{9'h008, 9'h12D, 9'h002, 9'h12D, 9'h001, 9'h13D};
    send_all();
    expect_result("8-2-1", 8'd5, 2, d0, e0, s0);

    // operand stack overflow on the ninth operand
    d0 = done_cnt; e0 = err_cnt; s0 = start_cnt;
    for (int k = 0; k < DEPTH + 1; k++) send_tok(1'b0, 8'(k + 1));
    tok_idle();
    step();
    chk("overflow err", err_cnt - e0, 1);
    chk("overflow stack cleared", {24'd0, opnd_Dout}, 0);
    chk("overflow no done", done_cnt - d0, 0);
    d0 = done_cnt; e0 = err_cnt; s0 = start_cnt;
    tq = '{9'h001, 9'h13D};
    send_all();
    expect_result("after overflow", 8'd1, 0, d0, e0, s0);

    // unknown operator code
    e0 = err_cnt;
    tq = '{9'h004, 9'h125};
    send_all();
    step();
    chk("unknown op err", err_cnt - e0, 1);
    chk("unknown op opnd cleared", {24'd0, opnd_Dout}, 0);
    chk("unknown op tok_ready", {31'd0, tok_ready}, 1);

    // '=' with nothing on the stacks
    e0 = err_cnt; d0 = done_cnt;
    tq = '{9'h13D};
    send_all();
    step();
    step();
    chk("lone eq err", err_cnt - e0, 1);
    chk("lone eq no done", done_cnt - d0, 0);

    // complete withheld for 20 cycles with the next token waiting
    calc_delay = 20;
    h0 = hold_viol;
    d0 = done_cnt; e0 = err_cnt; s0 = start_cnt;
    tq = '{9'h006, 9'h12A, 9'h007, 9'h12D, 9'h002, 9'h13D};
    send_all();
    expect_result("slow complete", 8'd40, 2, d0, e0, s0);
    chk("tok_ready low during wait", hold_viol - h0, 0);

    // reset in the middle of a reduction
    calc_delay = 30;
    tq = '{9'h005, 9'h12A, 9'h006};
    send_all();
    s0 = start_cnt;
    step();
    tok_valid = 1'b1;
    tok_is_op = 1'b1;
    tok_data  = 8'h3D;
    n = 0;
    while (start_cnt == s0 && n < 100) begin
      step();
      n++;
    end
    chk("mid-wait start seen", start_cnt - s0, 1);
    repeat (5) step();
    reset = 1'b1;
    tok_valid = 1'b0;
    #1;
    chk("mid reset tok_ready", {31'd0, tok_ready}, 1);
    chk("mid reset start", {31'd0, start}, 0);
    chk("mid reset done", {31'd0, done}, 0);
    chk("mid reset err", {31'd0, err}, 0);
    chk("mid reset result", {24'd0, result}, 0);
    chk("mid reset opnd_Dout", {24'd0, opnd_Dout}, 0);
    chk("mid reset op_Dout", {24'd0, op_Dout}, 0);
    step();
    reset = 1'b0;
    calc_delay = 0;
    repeat (3) step();
    d0 = done_cnt; e0 = err_cnt; s0 = start_cnt;
    tq = '{9'h005, 9'h12A, 9'h006, 9'h13D};
    send_all();
    expect_result("after reset 5*6", 8'd30, 1, d0, e0, s0);

    // random well-formed expressions
    for (int t = 0; t < 40; t++) begin
      nops = $urandom_range(0, 3);
      vals.delete();
      ops.delete();
      vals.push_back(8'($urandom));
      for (int k = 0; k < nops; k++) begin
        case ($urandom_range(0, 3))
          0:       o = 8'h2B;
          1:       o = 8'h2D;
          2:       o = 8'h2A;
          default: o = 8'h2F;
        endcase
        ops.push_back(o);
        vals.push_back((o == 8'h2F) ? 8'($urandom_range(1, 255)) : 8'($urandom));
      end
      tq.push_back({1'b0, vals[0]});
      foreach (ops[k]) begin
        tq.push_back({1'b1, ops[k]});
        tq.push_back({1'b0, vals[k+1]});
      end
      tq.push_back(9'h13D);
      calc_delay = $urandom_range(0, 3);
      d0 = done_cnt; e0 = err_cnt; s0 = start_cnt;
      send_all();
      expect_result($sformatf("rand%0d", t), ref_eval(vals, ops), nops, d0, e0, s0);
    end

    chk("start never with done/err", overlap, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
